// File: rtl/exu_mdu_handler_pkg.sv
// Shared RV32M decode constants for the execute-stage multiply/divide unit.
// Holds the funct3 encodings of the eight M-extension operations, the funct7
// value that selects them in decode, and small helpers that classify a funct3.
package exu_mdu_handler_pkg;

    localparam logic [2:0] MULDIV_FUNCT3_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_FUNCT3_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_FUNCT3_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_FUNCT3_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_FUNCT3_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_FUNCT3_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_FUNCT3_REM    = 3'd6;
    localparam logic [2:0] MULDIV_FUNCT3_REMU   = 3'd7;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Upper half of the funct3 space is the divide family.
    function automatic logic funct3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // REM and REMU return the remainder instead of the quotient.
    function automatic logic funct3_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    // DIV and REM are the signed divide ops (even funct3 within the family).
    function automatic logic funct3_is_signed_div(input logic [2:0] f3);
        return f3[2] & ~f3[0];
    endfunction

endpackage

// File: rtl/exu_mdu_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   abort               drops any division in progress
//   start               loads dividend/divisor and begins XLEN iterations
//   dividend, divisor   unsigned operands, sampled on start
//   busy                high while iterations remain
//   done                high during the cycle whose edge retires the last bit
//   quotient, remainder results, valid once busy has dropped; held until next start
module exu_mdu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dsr_q;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    diff;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the partial remainder while the new quotient bit enters at the LSB.
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dsr_q};

    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == LAST_ITER);
    assign quotient  = quo_q;
    assign remainder = rem_q;

    // Iteration register: a borrow out of the trial subtraction means the
    // divisor did not fit, so the shifted remainder is kept unchanged.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
        end else if (start) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
            quo_q  <= dividend;
            rem_q  <= '0;
            dsr_q  <= divisor;
        end else if (busy_q) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= rem_shift[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exu_mdu_handler.sv
// Multi-cycle RV32M multiply/divide unit for the execute stage.
// Ports:
//   clk, rst                  clock and synchronous active-high reset (beats flush)
//   flush                     aborts the in-flight op and drops a pending response
//   req_vld / req_rdy         request handshake; req_rdy is high only when idle
//   req_funct3                RV32M operation select
//   req_src1, req_src2        rs1 / rs2 operand values
//   req_rd                    destination register
//   rsp_vld / rsp_rdy         response handshake toward GPR writeback
//   rsp_rd, rsp_data          destination register and result, stable while stalled
module exu_mdu_handler
    import exu_mdu_handler_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4,
    parameter int RD_AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_src1,
    input  logic [XLEN-1:0]  req_src2,
    input  logic [RD_AW-1:0] req_rd,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [RD_AW-1:0] rsp_rd,
    output logic [XLEN-1:0]  rsp_data
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_STEP - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [RD_AW-1:0]  rd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] mcand_q, acc_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   res_q;
    logic              div_res_q, neg_quo_q, neg_rem_q;

    logic              accept, req_is_div, req_signed_div;
    logic              div_by_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res, neg_src1, neg_src2;
    logic [XLEN-1:0]   div_dividend, div_divisor;
    logic              a_signed, b_signed;
    logic [2*XLEN-1:0] mcand_init, acc_init, partial, acc_next;
    logic              op_is_div, last_step;
    logic              div_start, div_busy, div_done;
    logic [XLEN-1:0]   div_quo, div_rem, quo_fix, rem_fix, div_data;

    // Request decode and the divide corner cases that bypass iteration.
    assign accept         = (state_q == IDLE) && req_vld && !flush;
    assign req_is_div     = funct3_is_div(req_funct3);
    assign req_signed_div = funct3_is_signed_div(req_funct3);
    assign div_by_zero    = req_is_div && (req_src2 == '0);
    assign div_ovf        = req_signed_div && (req_src1 == MOST_NEG) && (req_src2 == '1);
    assign special        = div_by_zero || div_ovf;

    assign neg_src1 = ~req_src1 + XLEN'(1);
    assign neg_src2 = ~req_src2 + XLEN'(1);

    always_comb begin
        special_res = '0;
        if (div_by_zero) begin
            special_res = funct3_is_rem(req_funct3) ? req_src1 : '1;
        end else if (div_ovf) begin
            special_res = funct3_is_rem(req_funct3) ? '0 : req_src1;
        end
    end

    // The divider only sees magnitudes; signs are reapplied on the way out.
    assign div_dividend = (req_signed_div && req_src1[XLEN-1]) ? neg_src1 : req_src1;
    assign div_divisor  = (req_signed_div && req_src2[XLEN-1]) ? neg_src2 : req_src2;

    // Multiplicand is sign-extended when src1 is signed. The multiplier is
    // consumed as unsigned bits; a negative signed src2 is accounted for by
    // pre-loading the accumulator with -src1 * 2^XLEN.
    assign a_signed   = (req_funct3 == MULDIV_FUNCT3_MULH) || (req_funct3 == MULDIV_FUNCT3_MULHSU);
    assign b_signed   = (req_funct3 == MULDIV_FUNCT3_MULH);
    assign mcand_init = {{XLEN{a_signed & req_src1[XLEN-1]}}, req_src1};
    assign acc_init   = (b_signed && req_src2[XLEN-1]) ? {neg_src1, {XLEN{1'b0}}} : '0;

    assign partial  = mcand_q * {{(2*XLEN-MUL_STEP){1'b0}}, mplier_q[MUL_STEP-1:0]};
    assign acc_next = acc_q + partial;

    assign op_is_div = funct3_is_div(op_q);
    assign last_step = op_is_div ? (div_busy && div_done) : (cnt_q == MUL_LAST);
    assign div_start = accept && req_is_div && !special;

    exu_mdu_divider #(
        .XLEN(XLEN)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .abort     (flush),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Divide results keep the raw unsigned quotient/remainder registered and
    // apply the sign while the response is presented.
    assign quo_fix  = neg_quo_q ? (~div_quo + XLEN'(1)) : div_quo;
    assign rem_fix  = neg_rem_q ? (~div_rem + XLEN'(1)) : div_rem;
    assign div_data = funct3_is_rem(op_q) ? rem_fix : quo_fix;

    assign req_rdy  = (state_q == IDLE);
    assign rsp_vld  = (state_q == DONE);
    assign rsp_rd   = rd_q;
    assign rsp_data = (state_q == DONE) ? (div_res_q ? div_data : res_q) : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    if (rsp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Operand latch, iteration counter and shift-add multiplier datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            res_q     <= '0;
            div_res_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == CALC && state_d == CALC) ? cnt_q + CNT_W'(1) : '0;
            if (accept) begin
                op_q      <= req_funct3;
                rd_q      <= req_rd;
                mcand_q   <= mcand_init;
                acc_q     <= acc_init;
                mplier_q  <= req_src2;
                res_q     <= special_res;
                div_res_q <= req_is_div && !special;
                neg_quo_q <= req_signed_div && (req_src1[XLEN-1] ^ req_src2[XLEN-1]);
                neg_rem_q <= req_signed_div && req_src1[XLEN-1];
            end else if (state_q == CALC && !op_is_div) begin
                acc_q    <= acc_next;
                mcand_q  <= mcand_q << MUL_STEP;
                mplier_q <= mplier_q >> MUL_STEP;
                if (cnt_q == MUL_LAST) begin
                    res_q <= (op_q == MULDIV_FUNCT3_MUL) ? acc_next[XLEN-1:0]
                                                         : acc_next[2*XLEN-1:XLEN];
                end
            end
        end
    end

endmodule

// File: tb/tb_exu_mdu_handler.sv
// Self-checking bench for exu_mdu_handler at default parameters.
// A transaction-level reference model predicts handshake signals and results
// every cycle; directed vectors additionally pin literal results and latencies.
module tb_exu_mdu_handler;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_vld;
    logic        req_rdy;
    logic [2:0]  req_funct3;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic [4:0]  req_rd;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    bit          m_pending = 1'b0;
    bit          m_vld     = 1'b0;
    int          m_wait    = 0;
    logic [31:0] m_data    = '0;
    logic [4:0]  m_rd      = '0;

    exu_mdu_handler dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_funct3 (req_funct3),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .req_rd     (req_rd),
        .rsp_vld    (rsp_vld),
        .rsp_rdy    (rsp_rdy),
        .rsp_rd     (rsp_rd),
        .rsp_data   (rsp_data)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls beyond every per-wait bound.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural RV32M result, computed with wide integer arithmetic.
    function automatic logic [31:0] modelResult(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        p  = '0;
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Cycles from accept edge until the response is visible.
    function automatic int modelLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 9;
        if (b == 32'd0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Reference model: one outstanding op, predicted result appears after
    // its latency and stays until writeback accepts; rst/flush discard it.
    always @(posedge clk) begin
        if (rst || flush) begin
            m_pending = 1'b0;
            m_vld     = 1'b0;
        end else if (m_vld) begin
            if (rsp_rdy) m_vld = 1'b0;
        end else if (m_pending) begin
            m_wait--;
            if (m_wait == 0) begin
                m_pending = 1'b0;
                m_vld     = 1'b1;
            end
        end else if (req_vld) begin
            m_data = modelResult(req_funct3, req_src1, req_src2);
            m_rd   = req_rd;
            m_wait = modelLatency(req_funct3, req_src1, req_src2) - 1;
            if (m_wait == 0) m_vld = 1'b1;
            else             m_pending = 1'b1;
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model req_rdy", 32'(req_rdy), 32'(!(m_pending || m_vld)));
            checkOutput("model rsp_vld", 32'(rsp_vld), 32'(m_vld));
            if (m_vld) begin
                checkOutput("model rsp_data", rsp_data, m_data);
                checkOutput("model rsp_rd", 32'(rsp_rd), 32'(m_rd));
            end
        end
    end

    // Issue one op from IDLE, measure latency, optionally stall writeback for
    // `hold` cycles, and compare against hand-computed literals.
    task automatic applyStimulus(input string name, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] exp_data, input int exp_lat, input int hold);
        int lat;
        rsp_rdy    = (hold == 0);
        req_funct3 = f;
        req_src1   = a;
        req_src2   = b;
        req_rd     = rd;
        req_vld    = 1'b1;
        @(posedge clk);
        #1 req_vld = 1'b0;
        lat = 1;
        while (!rsp_vld && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, " data"}, rsp_data, exp_data);
        checkOutput({name, " rd"}, 32'(rsp_rd), 32'(rd));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput({name, " held vld"}, 32'(rsp_vld), 32'd1);
            checkOutput({name, " held data"}, rsp_data, exp_data);
            checkOutput({name, " held rd"}, 32'(rsp_rd), 32'(rd));
            checkOutput({name, " held req_rdy"}, 32'(req_rdy), 32'd0);
        end
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({name, " idle after handshake"}, 32'(req_rdy), 32'd1);
    endtask

    // Directed sequence.
    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req_vld    = 1'b0;
        req_funct3 = '0;
        req_src1   = '0;
        req_src2   = '0;
        req_rd     = '0;
        rsp_rdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset req_rdy", 32'(req_rdy), 32'd1);
        checkOutput("reset rsp_vld", 32'(rsp_vld), 32'd0);
        checkOutput("reset rsp_data", rsp_data, 32'd0);
        checkOutput("reset rsp_rd", 32'(rsp_rd), 32'd0);
        chk_en = 1'b1;

        applyStimulus("MUL 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 9,  0);
        applyStimulus("MULH min*min",    3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, 9,  0);
        applyStimulus("MULHSU -1*max",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 9,  0);
        applyStimulus("MULHU max*max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 9,  0);
        applyStimulus("MULHSU min*2^31", 3'd2, 32'h8000_0000,  32'h8000_0000, 5'd5,  32'hC000_0000, 9,  0);
        applyStimulus("DIV -7/2",        3'd4, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFD, 33, 0);
        applyStimulus("REM -7/2",        3'd6, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFF, 33, 0);
        applyStimulus("DIV 7/-2",        3'd4, 32'd7,          32'hFFFF_FFFE, 5'd8,  32'hFFFF_FFFD, 33, 0);
        applyStimulus("DIVU 100/7",      3'd5, 32'd100,        32'd7,         5'd9,  32'd14,        33, 0);
        applyStimulus("REMU 100/7",      3'd7, 32'd100,        32'd7,         5'd10, 32'd2,         33, 0);
        applyStimulus("DIVU 5/0",        3'd5, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 1,  0);
        applyStimulus("REMU 5/0",        3'd7, 32'd5,          32'd0,         5'd12, 32'd5,         1,  0);
        applyStimulus("DIV ovf",         3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1,  0);
        applyStimulus("REM ovf",         3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,         1,  0);
        applyStimulus("backpressure",    3'd3, 32'h1234_5678,  32'h0000_0010, 5'd17, 32'd1,         9,  5);

        // flush in IDLE while a request is offered: nothing is accepted.
        req_funct3 = 3'd0; req_src1 = 32'd3; req_src2 = 32'd3; req_rd = 5'd20;
        req_vld = 1'b1;
        flush   = 1'b1;
        @(posedge clk);
        #1 req_vld = 1'b0;
        flush = 1'b0;
        checkOutput("idle flush req_rdy", 32'(req_rdy), 32'd1);
        repeat (12) @(posedge clk);
        #1 checkOutput("idle flush no rsp", 32'(rsp_vld), 32'd0);

        // flush during the third CALC cycle of a multiply.
        req_funct3 = 3'd0; req_src1 = 32'd7; req_src2 = 32'd3; req_rd = 5'd21;
        req_vld = 1'b1;
        @(posedge clk);
        #1 req_vld = 1'b0;
        checkOutput("calc req_rdy low", 32'(req_rdy), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checkOutput("calc flush req_rdy", 32'(req_rdy), 32'd1);
        checkOutput("calc flush rsp_vld", 32'(rsp_vld), 32'd0);
        repeat (12) @(posedge clk);
        #1 checkOutput("calc flush no rsp", 32'(rsp_vld), 32'd0);

        // rst in the middle of a divide.
        req_funct3 = 3'd5; req_src1 = 32'd100; req_src2 = 32'd7; req_rd = 5'd22;
        req_vld = 1'b1;
        @(posedge clk);
        #1 req_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("calc rst req_rdy", 32'(req_rdy), 32'd1);
        repeat (40) @(posedge clk);
        #1 checkOutput("calc rst no rsp", 32'(rsp_vld), 32'd0);

        // rst while a stalled response sits in DONE.
        rsp_rdy = 1'b0;
        req_funct3 = 3'd5; req_src1 = 32'd5; req_src2 = 32'd0; req_rd = 5'd23;
        req_vld = 1'b1;
        @(posedge clk);
        #1 req_vld = 1'b0;
        checkOutput("done before rst vld", 32'(rsp_vld), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rsp_rdy = 1'b1;
        checkOutput("done rst rsp_vld", 32'(rsp_vld), 32'd0);
        checkOutput("done rst req_rdy", 32'(req_rdy), 32'd1);
        checkOutput("done rst rsp_data", rsp_data, 32'd0);

        applyStimulus("MULHU 3*5", 3'd3, 32'd3, 32'd5, 5'd24, 32'd0, 9, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
